// File: rtl/rf_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_pkg
// Shared types for the register-file write arbiter: register index and data
// word types, the queued write record, the arbiter state encoding and a
// small helper that matches a queued record against a register index.
// ---------------------------------------------------------------------------
package rf_write_arbiter_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    // One queued multicycle result; live=0 means it must never reach the port.
    typedef struct packed {
        logic     live;
        regbits_t wsel;
        word_t    wdat;
    } rf_wr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } rfarb_state_t;

    // True when a live record targets register r; r0 never matches.
    function automatic logic wsel_hit(input rf_wr_t e, input regbits_t r);
        return e.live && (e.wsel == r) && (r != '0);
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter_if
// Bundles the pipeline writeback, multicycle result and register-file write
// signals around rf_write_arbiter.
//   pl_wen/pl_wsel/pl_wdat  pipeline WB write request
//   pl_stall                WB must hold its request this cycle
//   mc_valid/mc_wsel/mc_wdat multicycle result, mc_ready = queue can accept
//   rf_wen/rf_wsel/rf_wdat  register file write port
// Optional macro RF_ARB_FWD_EN adds fw_rsel1/2 lookups with fw_hit1/2 and
// fw_dat1/2 results forwarded from the queue.
// Modports: slave (the arbiter), master (WB/MC/RF side).
// ---------------------------------------------------------------------------
interface rf_write_arbiter_if;
    import rf_write_arbiter_pkg::*;

    logic     pl_wen;
    regbits_t pl_wsel;
    word_t    pl_wdat;
    logic     pl_stall;
    logic     mc_valid;
    logic     mc_ready;
    regbits_t mc_wsel;
    word_t    mc_wdat;
    logic     rf_wen;
    regbits_t rf_wsel;
    word_t    rf_wdat;
`ifdef RF_ARB_FWD_EN
    regbits_t fw_rsel1;
    regbits_t fw_rsel2;
    logic     fw_hit1;
    logic     fw_hit2;
    word_t    fw_dat1;
    word_t    fw_dat2;
`endif

    modport slave (
        input  pl_wen, pl_wsel, pl_wdat, mc_valid, mc_wsel, mc_wdat,
        output pl_stall, mc_ready, rf_wen, rf_wsel, rf_wdat
`ifdef RF_ARB_FWD_EN
        ,
        input  fw_rsel1, fw_rsel2,
        output fw_hit1, fw_hit2, fw_dat1, fw_dat2
`endif
    );

    modport master (
        output pl_wen, pl_wsel, pl_wdat, mc_valid, mc_wsel, mc_wdat,
        input  pl_stall, mc_ready, rf_wen, rf_wsel, rf_wdat
`ifdef RF_ARB_FWD_EN
        ,
        output fw_rsel1, fw_rsel2,
        input  fw_hit1, fw_hit2, fw_dat1, fw_dat2
`endif
    );

endinterface

// File: rtl/rf_write_arbiter_wb_fifo.sv
// ---------------------------------------------------------------------------
// rf_wb_fifo
// DEPTH-entry circular buffer of rf_wr_t with per-entry kill by register
// index. A kill also applies to the record pushed in the same cycle.
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_push, i_push_data enqueue (ignored when full)
//   i_pop               dequeue head (ignored when empty)
//   i_kill, i_kill_wsel clear live on every entry targeting i_kill_wsel
//   o_head              head record (valid when !o_empty)
//   o_full, o_empty, o_count  occupancy, all from registered state
//   o_slot              (RF_ARB_FWD_EN) entries oldest-first, live masked
//                       off for unoccupied slots
// ---------------------------------------------------------------------------
module rf_wb_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  rf_wr_t                 i_push_data,
    input  logic                   i_pop,
    input  logic                   i_kill,
    input  regbits_t               i_kill_wsel,
    output rf_wr_t                 o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
`ifdef RF_ARB_FWD_EN
    ,
    output rf_wr_t                 o_slot [DEPTH]
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    rf_wr_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;
    rf_wr_t        w_push_entry;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // A same-cycle pipeline write to the same register is younger, so the
    // incoming record is stored already dead.
    always_comb begin
        w_push_entry      = i_push_data;
        w_push_entry.live = i_push_data.live &&
                            !(i_kill && (i_push_data.wsel == i_kill_wsel));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i_kill && wsel_hit(r_mem[i], i_kill_wsel)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= w_push_entry;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef RF_ARB_FWD_EN
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_slot[i] = r_mem[r_rd_ptr + PW'(i)];
            if (CW'(i) >= r_count) begin
                o_slot[i].live = 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the register file's single write port between the pipeline WB
// stage (priority) and a multicycle unit whose results queue in rf_wb_fifo
// and drain into idle write cycles. A live queue head blocked STARVE_MAX
// times in a row forces a one-cycle DRAIN that stalls WB and retires it.
//   CLK, nRST  clock, asynchronous active-low reset
//   bus        rf_write_arbiter_if.slave: pl_*, mc_*, rf_* (and fw_* when
//              RF_ARB_FWD_EN is defined, forwarding queued values to decode)
// Parameters: DEPTH (power of 2, >=2), STARVE_MAX (>=1).
// ---------------------------------------------------------------------------
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    rf_write_arbiter_if.slave     bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    rfarb_state_t  r_state;
    rfarb_state_t  w_state_nxt;
    logic [SW-1:0] r_starve;
    logic [SW-1:0] w_starve_nxt;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    rf_wr_t        w_head;
    rf_wr_t        w_push_data;
    logic          w_full;
    logic          w_empty;
    logic          w_drain;
    logic          w_head_live;
    logic          w_pl_req;
    logic          w_blocked;
    logic          w_push;
    logic          w_pop;
    logic          w_go_drain;
`ifdef RF_ARB_FWD_EN
    rf_wr_t        w_slot [DEPTH];
`endif

    assign w_drain     = (r_state == DRAIN);
    assign w_head_live = !w_empty && w_head.live;
    // WB request is ignored while stalled; r0 writes never use the port.
    assign w_pl_req    = bus.pl_wen && (bus.pl_wsel != '0) && !w_drain;
    assign w_blocked   = w_head_live && w_pl_req;
    assign w_push      = bus.mc_valid && !w_full;
    // Dead heads pop whenever seen; a live head pops only when it owns the port.
    assign w_pop       = !w_empty && (w_drain || !w_head.live || !w_pl_req);
    assign w_go_drain  = w_blocked && (r_starve == SW'(STARVE_MAX - 1));

    always_comb begin
        w_push_data      = '0;
        w_push_data.live = (bus.mc_wsel != '0);
        w_push_data.wsel = bus.mc_wsel;
        w_push_data.wdat = bus.mc_wdat;
    end

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (CLK),
        .i_rst_n     (nRST),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_kill      (w_pl_req),
        .i_kill_wsel (bus.pl_wsel),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
`ifdef RF_ARB_FWD_EN
        ,
        .o_slot      (w_slot)
`endif
    );

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // Next state; IDLE/PEND simply track occupancy after this cycle's update.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = w_count + CW'(1);
            2'b01:   w_count_nxt = w_count - CW'(1);
            default: w_count_nxt = w_count;
        endcase

        if (w_go_drain) begin
            w_state_nxt = DRAIN;
        end else if (w_count_nxt != '0) begin
            w_state_nxt = PEND;
        end else begin
            w_state_nxt = IDLE;
        end

        w_starve_nxt = r_starve;
        if (w_pop) begin
            w_starve_nxt = '0;
        end else if (w_blocked && (r_starve != SW'(STARVE_MAX - 1))) begin
            w_starve_nxt = r_starve + SW'(1);
        end
    end

    // Outputs
    always_comb begin
        bus.pl_stall = w_drain;
        bus.mc_ready = !w_full;
        bus.rf_wen   = 1'b0;
        bus.rf_wsel  = bus.pl_wsel;
        bus.rf_wdat  = bus.pl_wdat;
        if (w_drain) begin
            bus.rf_wen  = w_head_live;
            bus.rf_wsel = w_head.wsel;
            bus.rf_wdat = w_head.wdat;
        end else if (w_pl_req) begin
            bus.rf_wen  = 1'b1;
        end else if (w_head_live) begin
            bus.rf_wen  = 1'b1;
            bus.rf_wsel = w_head.wsel;
            bus.rf_wdat = w_head.wdat;
        end
    end

`ifdef RF_ARB_FWD_EN
    // Slots are oldest-first, so the last match is the youngest.
    always_comb begin
        bus.fw_hit1 = 1'b0;
        bus.fw_dat1 = '0;
        bus.fw_hit2 = 1'b0;
        bus.fw_dat2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wsel_hit(w_slot[i], bus.fw_rsel1)) begin
                bus.fw_hit1 = 1'b1;
                bus.fw_dat1 = w_slot[i].wdat;
            end
            if (wsel_hit(w_slot[i], bus.fw_rsel2)) begin
                bus.fw_hit2 = 1'b1;
                bus.fw_dat2 = w_slot[i].wdat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
// Table-driven and hand-sequenced stimulus for rf_write_arbiter
// (DEPTH=2, STARVE_MAX=4). Expected outputs are queued as each cycle is
// driven and compared at the falling edge. A shadow register file built from
// rf_* writes is checked at the end. Forwarding is exercised when
// RF_ARB_FWD_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic        pl_wen;
        logic [4:0]  pl_wsel;
        logic [31:0] pl_wdat;
        logic        mc_valid;
        logic [4:0]  mc_wsel;
        logic [31:0] mc_wdat;
        logic        e_stall;
        logic        e_ready;
        logic        e_wen;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
    } vec_t;

    typedef struct {
        int          id;
        logic        stall;
        logic        ready;
        logic        wen;
        logic [4:0]  wsel;
        logic [31:0] wdat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] shadow [32];

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 32; i++) shadow[i] <= '0;
        end else if (bus.rf_wen) begin
            shadow[bus.rf_wsel] <= bus.rf_wdat;
        end
    end

    function automatic vec_t mk(input logic pw, input logic [4:0] ps, input logic [31:0] pd,
                                input logic mv, input logic [4:0] ms, input logic [31:0] md,
                                input logic es, input logic er, input logic ew,
                                input logic [4:0] ews, input logic [31:0] ewd);
        vec_t v;
        v.pl_wen = pw; v.pl_wsel = ps; v.pl_wdat = pd;
        v.mc_valid = mv; v.mc_wsel = ms; v.mc_wdat = md;
        v.e_stall = es; v.e_ready = er; v.e_wen = ew; v.e_wsel = ews; v.e_wdat = ewd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.pl_wen   = v.pl_wen;
        bus.pl_wsel  = v.pl_wsel;
        bus.pl_wdat  = v.pl_wdat;
        bus.mc_valid = v.mc_valid;
        bus.mc_wsel  = v.mc_wsel;
        bus.mc_wdat  = v.mc_wdat;
    endtask

    task automatic expect_push(input int id, input vec_t v);
        exp_t e;
        e.id = id; e.stall = v.e_stall; e.ready = v.e_ready;
        e.wen = v.e_wen; e.wsel = v.e_wsel; e.wdat = v.e_wdat;
        sb_q.push_back(e);
    endtask

    task automatic compare_pop();
        exp_t e;
        logic ok;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: got empty queue, want a pending expectation");
            return;
        end
        e  = sb_q.pop_front();
        ok = (bus.pl_stall === e.stall) && (bus.mc_ready === e.ready) && (bus.rf_wen === e.wen);
        if (e.wen) ok = ok && (bus.rf_wsel === e.wsel) && (bus.rf_wdat === e.wdat);
        if (!ok) begin
            n_bad++;
            $display("FAIL vec%0d: got stall=%b ready=%b wen=%b wsel=%0d wdat=%h, want stall=%b ready=%b wen=%b wsel=%0d wdat=%h",
                     e.id, bus.pl_stall, bus.mc_ready, bus.rf_wen, bus.rf_wsel, bus.rf_wdat,
                     e.stall, e.ready, e.wen, e.wsel, e.wdat);
        end
    endtask

    task automatic step(input int id, input vec_t v);
        @(posedge CLK);
        #1;
        drive(v);
        expect_push(id, v);
        @(negedge CLK);
        compare_pop();
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    vec_t tbl [14];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[0]  = mk(0, 0, 0,        1, 5, 32'hAAAA, 0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,        0, 0, 0,        0, 1, 1, 5, 32'hAAAA);
        tbl[2]  = idle;
        tbl[3]  = mk(1, 1, 32'h11,   0, 0, 0,        0, 1, 1, 1, 32'h11);
        tbl[4]  = mk(1, 0, 32'h22,   0, 0, 0,        0, 1, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0,        1, 0, 32'h33,   0, 1, 0, 0, 0);
        tbl[6]  = idle;
        tbl[7]  = idle;
        tbl[8]  = mk(1, 2, 32'h222,  1, 6, 32'h66,   0, 1, 1, 2, 32'h222);
        tbl[9]  = mk(0, 0, 0,        0, 0, 0,        0, 1, 1, 6, 32'h66);
        tbl[10] = idle;
        tbl[11] = mk(1, 10, 32'hB0,  1, 10, 32'hC0,  0, 1, 1, 10, 32'hB0);
        tbl[12] = idle;
        tbl[13] = idle;

        nRST = 1'b0;
        drive(idle);
`ifdef RF_ARB_FWD_EN
        bus.fw_rsel1 = '0;
        bus.fw_rsel2 = '0;
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        expect_push(0, idle);
        compare_pop();
        @(posedge CLK);
        #1 nRST = 1'b1;

        // Reset while two results are queued discards them.
        step(100, mk(1, 1, 32'h1, 1, 20, 32'h2020, 0, 1, 1, 1, 32'h1));
        step(101, mk(1, 1, 32'h1, 1, 21, 32'h2121, 0, 1, 1, 1, 32'h1));
        @(posedge CLK);
        #1;
        drive(idle);
        expect_push(102, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 32'h2020));
        #1 compare_pop();
        nRST = 1'b0;
        #1;
        expect_push(103, idle);
        compare_pop();
        @(posedge CLK);
        #1 nRST = 1'b1;
        step(104, idle);
        step(105, idle);

        for (int i = 0; i < 14; i++) step(i + 1, tbl[i]);

        // Starvation: four blocked cycles, then a forced drain.
        step(200, mk(1, 3, 32'h30, 1, 7, 32'h77, 0, 1, 1, 3, 32'h30));
        for (int k = 0; k < 4; k++)
            step(201 + k, mk(1, 3, 32'h31 + k, 0, 0, 0, 0, 1, 1, 3, 32'h31 + k));
        step(205, mk(1, 3, 32'h35, 0, 0, 0, 1, 1, 1, 7, 32'h77));
        step(206, mk(1, 3, 32'h35, 0, 0, 0, 0, 1, 1, 3, 32'h35));
        step(207, idle);

        // WAW kill of a queued r9.
        step(300, mk(1, 4, 32'h40, 1, 9, 32'hDEAD, 0, 1, 1, 4, 32'h40));
        step(301, mk(1, 9, 32'h1,  0, 0, 0,        0, 1, 1, 9, 32'h1));
        step(302, idle);
        step(303, idle);

        // Full queue: third result waits, order preserved.
        step(400, mk(1, 1, 32'h10, 1, 11, 32'h1100, 0, 1, 1, 1, 32'h10));
        step(401, mk(1, 1, 32'h11, 1, 12, 32'h1200, 0, 1, 1, 1, 32'h11));
        step(402, mk(1, 1, 32'h12, 1, 13, 32'h1300, 0, 0, 1, 1, 32'h12));
        step(403, mk(0, 0, 0,      1, 13, 32'h1300, 0, 0, 1, 11, 32'h1100));
        step(404, mk(0, 0, 0,      1, 13, 32'h1300, 0, 1, 1, 12, 32'h1200));
        step(405, mk(0, 0, 0,      0, 0, 0,         0, 1, 1, 13, 32'h1300));
        step(406, idle);

        // Drain of a head killed on the triggering cycle; second entry survives.
        step(500, mk(1, 2, 32'h20, 1, 14, 32'hE0, 0, 1, 1, 2, 32'h20));
        step(501, mk(1, 2, 32'h21, 1, 15, 32'hF0, 0, 1, 1, 2, 32'h21));
        step(502, mk(1, 2, 32'h22, 0, 0, 0,       0, 0, 1, 2, 32'h22));
        step(503, mk(1, 2, 32'h23, 0, 0, 0,       0, 0, 1, 2, 32'h23));
        step(504, mk(1, 14, 32'h24, 0, 0, 0,      0, 0, 1, 14, 32'h24));
        step(505, mk(1, 2, 32'h25, 0, 0, 0,       1, 0, 0, 0, 0));
        step(506, mk(1, 2, 32'h25, 0, 0, 0,       0, 1, 1, 2, 32'h25));
        step(507, mk(0, 0, 0,      0, 0, 0,       0, 1, 1, 15, 32'hF0));
        step(508, idle);

`ifdef RF_ARB_FWD_EN
        step(600, mk(1, 2, 32'h1, 1, 4, 32'h10, 0, 1, 1, 2, 32'h1));
        step(601, mk(1, 2, 32'h2, 1, 4, 32'h20, 0, 1, 1, 2, 32'h2));
        @(posedge CLK);
        #1;
        drive(mk(1, 2, 32'h3, 0, 0, 0, 0, 0, 1, 2, 32'h3));
        bus.fw_rsel1 = 5'd4;
        bus.fw_rsel2 = 5'd0;
        expect_push(602, mk(1, 2, 32'h3, 0, 0, 0, 0, 0, 1, 2, 32'h3));
        @(negedge CLK);
        compare_pop();
        check_val("fw_hit1", {31'd0, bus.fw_hit1}, 32'd1);
        check_val("fw_dat1", bus.fw_dat1, 32'h20);
        check_val("fw_hit2", {31'd0, bus.fw_hit2}, 32'd0);
        bus.fw_rsel1 = '0;
        step(603, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 32'h10));
        step(604, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 32'h20));
        step(605, idle);
`endif

        @(posedge CLK);
        #1;
        check_val("r5",  shadow[5],  32'hAAAA);
        check_val("r3",  shadow[3],  32'h35);
        check_val("r7",  shadow[7],  32'h77);
        check_val("r9",  shadow[9],  32'h1);
        check_val("r10", shadow[10], 32'hB0);
        check_val("r13", shadow[13], 32'h1300);
        check_val("r14", shadow[14], 32'h24);
        check_val("r15", shadow[15], 32'hF0);
        check_val("r20", shadow[20], 32'h0);
        check_val("r21", shadow[21], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100us, want completion");
        $fatal(1);
    end

endmodule
